// File: rtl/cordic_pkg.sv
// Shared definitions for the sequential CORDIC controller: coordinate-system
// encoding, FSM state type and the hyperbolic repeat indices.
package cordic_pkg;

  typedef enum logic [1:0] {
    CoordCircular   = 2'b00,
    CoordLinear     = 2'b01,
    CoordHyperbolic = 2'b10
  } coord_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StLoad = 2'b01,
    StIter = 2'b10,
    StDone = 2'b11
  } state_e;

  // Hyperbolic convergence needs these shift values executed twice.
  localparam int unsigned RepIdx0 = 4;
  localparam int unsigned RepIdx1 = 13;
  localparam int unsigned RepIdx2 = 40;

  // Both 2'b10 and 2'b11 select hyperbolic.
  function automatic logic is_hyperbolic(logic [1:0] cs);
    return cs[1];
  endfunction

  function automatic logic is_repeat_idx(int unsigned idx);
    return (idx == RepIdx0) || (idx == RepIdx1) || (idx == RepIdx2);
  endfunction

endpackage

// File: rtl/cordic_shift_gen.sv
// Shift/ROM-index counter for the CORDIC sequencer, with the hyperbolic
// repeat-once flag and end-of-run detection.
module cordic_shift_gen
  import cordic_pkg::*;
#(
  parameter int unsigned N_ITER = 16,
  parameter int unsigned IDX_W  = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             init_i,
  input  logic             advance_i,
  input  logic             hyperbolic_i,
  output logic [IDX_W-1:0] shift_o,
  output logic             last_o
);

  logic [IDX_W-1:0] shift_q, shift_d;
  logic             rep_q, rep_d;
  logic             rep_pending;

  // First pass over a repeat index in hyperbolic mode: hold the shift one more step.
  assign rep_pending = hyperbolic_i & is_repeat_idx(32'(shift_q)) & ~rep_q;

  assign last_o  = (shift_q == IDX_W'(N_ITER - 1)) & ~rep_pending;
  assign shift_o = shift_q;

  always_comb begin
    shift_d = shift_q;
    rep_d   = rep_q;
    if (init_i) begin
      shift_d = hyperbolic_i ? IDX_W'(1) : '0;
      rep_d   = 1'b0;
    end else if (advance_i) begin
      if (rep_pending) begin
        rep_d = 1'b1;
      end else begin
        shift_d = shift_q + IDX_W'(1);
        rep_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      rep_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      rep_q   <= rep_d;
    end
  end

endmodule

// File: rtl/cordic_seq.sv
// Control sequencer for an iterative CORDIC datapath: load strobe, per-step
// shift index and rotation direction, and a valid/ready result handshake.
module cordic_seq
  import cordic_pkg::*;
#(
  parameter int unsigned N_ITER = 16,
  parameter int unsigned IDX_W  = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       coordinate_system_i,
  input  logic             vectoring_i,
  input  logic             abort_i,
  input  logic             z_sign_i,
  input  logic             y_sign_i,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic             load_o,
  output logic             iter_en_o,
  output logic [IDX_W-1:0] shift_o,
  output logic             dir_o,
  output logic             out_valid_o
);

  state_e state_q, state_d;
  logic   hyp_q, hyp_d;
  logic   vec_q, vec_d;
  logic   busy_q, busy_d;
  logic   load_q, load_d;
  logic   iter_en_q, iter_en_d;
  logic   out_valid_q, out_valid_d;
  logic   last;

  cordic_shift_gen #(
    .N_ITER(N_ITER),
    .IDX_W (IDX_W)
  ) u_shift_gen (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .init_i      (state_q == StLoad),
    .advance_i   (state_q == StIter),
    .hyperbolic_i(hyp_q),
    .shift_o     (shift_o),
    .last_o      (last)
  );

  always_comb begin
    state_d = state_q;
    hyp_d   = hyp_q;
    vec_d   = vec_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StLoad;
          hyp_d   = is_hyperbolic(coordinate_system_i);
          vec_d   = vectoring_i;
        end
      end
      StLoad: state_d = StIter;
      StIter: if (last) state_d = StDone;
      StDone: if (out_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort_i && (state_q != StIdle)) begin
      state_d = StIdle;
    end
    // Outputs are registered copies of the next-state decode, so they are glitch-free.
    busy_d      = (state_d != StIdle);
    load_d      = (state_d == StLoad);
    iter_en_d   = (state_d == StIter);
    out_valid_d = (state_d == StDone);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      hyp_q       <= 1'b0;
      vec_q       <= 1'b0;
      busy_q      <= 1'b0;
      load_q      <= 1'b0;
      iter_en_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hyp_q       <= hyp_d;
      vec_q       <= vec_d;
      busy_q      <= busy_d;
      load_q      <= load_d;
      iter_en_q   <= iter_en_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy_o      = busy_q;
  assign load_o      = load_q;
  assign iter_en_o   = iter_en_q;
  assign out_valid_o = out_valid_q;
  // Rotation drives z toward zero, vectoring drives y toward zero.
  assign dir_o       = iter_en_q & (vec_q ? y_sign_i : ~z_sign_i);

endmodule

// File: tb/tb_cordic_seq.sv
// Self-checking bench for cordic_seq: table of full runs plus directed
// handshake, abort and mid-run reset sequences.
module tb_cordic_seq;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       start_i = 1'b0;
  logic [1:0] coordinate_system_i = 2'b00;
  logic       vectoring_i = 1'b0;
  logic       abort_i = 1'b0;
  logic       z_sign_i = 1'b0;
  logic       y_sign_i = 1'b0;
  logic       out_ready_i = 1'b0;

  logic       busy_a, load_a, iter_a, dir_a, ov_a;
  logic [5:0] shift_a;
  logic       busy_b, load_b, iter_b, dir_b, ov_b;
  logic [5:0] shift_b;

  bit         use_b = 1'b0;
  logic       m_busy, m_load, m_iter, m_dir, m_ov;
  logic [5:0] m_shift;

  assign m_busy  = use_b ? busy_b  : busy_a;
  assign m_load  = use_b ? load_b  : load_a;
  assign m_iter  = use_b ? iter_b  : iter_a;
  assign m_dir   = use_b ? dir_b   : dir_a;
  assign m_ov    = use_b ? ov_b    : ov_a;
  assign m_shift = use_b ? shift_b : shift_a;

  cordic_seq #(.N_ITER(16), .IDX_W(6)) u_dut16 (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .coordinate_system_i(coordinate_system_i), .vectoring_i(vectoring_i),
    .abort_i(abort_i), .z_sign_i(z_sign_i), .y_sign_i(y_sign_i),
    .out_ready_i(out_ready_i), .busy_o(busy_a), .load_o(load_a),
    .iter_en_o(iter_a), .shift_o(shift_a), .dir_o(dir_a), .out_valid_o(ov_a)
  );

  cordic_seq #(.N_ITER(41), .IDX_W(6)) u_dut41 (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .coordinate_system_i(coordinate_system_i), .vectoring_i(vectoring_i),
    .abort_i(abort_i), .z_sign_i(z_sign_i), .y_sign_i(y_sign_i),
    .out_ready_i(out_ready_i), .busy_o(busy_b), .load_o(load_b),
    .iter_en_o(iter_b), .shift_o(shift_b), .dir_o(dir_b), .out_valid_o(ov_b)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  coord;
    logic        vec;
    bit          big;
    int          n_iter;
    int          steps;
    int          ov_cycle;
  } vec_t;

  vec_t tbl[7];
  int   n_tests = 0;
  int   n_fail = 0;
  int   exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic build_exp(input bit hyp, input int n);
    exp_q.delete();
    for (int v = (hyp ? 1 : 0); v < n; v++) begin
      exp_q.push_back(v);
      if (hyp && (v == 4 || v == 13 || v == 40)) exp_q.push_back(v);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(m_busy), 0);
    chk({tag, "_load"}, 32'(m_load), 0);
    chk({tag, "_iter"}, 32'(m_iter), 0);
    chk({tag, "_shift"}, 32'(m_shift), 0);
    chk({tag, "_dir"}, 32'(m_dir), 0);
    chk({tag, "_ov"}, 32'(m_ov), 0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    start_i = 1'b0; abort_i = 1'b0; out_ready_i = 1'b0;
    z_sign_i = 1'b0; y_sign_i = 1'b0;
    #1;
    check_all_zero("reset");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  // Waits for the selected DUT to reach ITER with a given shift; bounded.
  task automatic wait_shift(input int target, output bit found);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clk_i); #1;
      if (m_iter && m_shift == 6'(target)) found = 1'b1;
    end
    if (!found) chk("wait_shift_timeout", 0, 1);
  endtask

  // Starts a run from IDLE (caller is #1 after an edge) and follows it to DONE.
  task automatic run_vec(input vec_t v, input bit release_done);
    int  cyc;
    int  idx;
    bit  got_ov;
    logic exp_dir;
    use_b = v.big;
    build_exp(v.coord[1], v.n_iter);
    coordinate_system_i = v.coord;
    vectoring_i = v.vec;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    // Mode inputs change after acceptance; the run must use the latched values.
    coordinate_system_i = ~v.coord;
    vectoring_i = ~v.vec;
    cyc = 1;
    chk("load_cycle1", 32'(m_load), 1);
    chk("iter_cycle1", 32'(m_iter), 0);
    chk("busy_cycle1", 32'(m_busy), 1);
    chk("dir_cycle1", 32'(m_dir), 0);
    idx = 0;
    got_ov = 1'b0;
    for (int k = 0; k < 80 && !got_ov; k++) begin
      @(posedge clk_i); #1;
      cyc++;
      z_sign_i = 1'($urandom_range(0, 1));
      y_sign_i = 1'($urandom_range(0, 1));
      #1;
      if (m_ov) begin
        got_ov = 1'b1;
      end else begin
        exp_dir = v.vec ? y_sign_i : ~z_sign_i;
        chk("iter_en", 32'(m_iter), 1);
        chk("load_low", 32'(m_load), 0);
        if (idx < exp_q.size()) chk("shift", 32'(m_shift), 32'(exp_q[idx]));
        else chk("too_many_steps", 32'(idx), 32'(exp_q.size()));
        chk("dir", 32'(m_dir), 32'(exp_dir));
        idx++;
      end
    end
    if (!got_ov) chk("ov_timeout", 0, 1);
    chk("ov_cycle", 32'(cyc), 32'(v.ov_cycle));
    chk("step_count", 32'(idx), 32'(v.steps));
    chk("done_iter", 32'(m_iter), 0);
    chk("done_dir", 32'(m_dir), 0);
    chk("done_busy", 32'(m_busy), 1);
    if (release_done) begin
      out_ready_i = 1'b1;
      @(posedge clk_i); #1;
      out_ready_i = 1'b0;
      chk("release_busy", 32'(m_busy), 0);
      chk("release_ov", 32'(m_ov), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit found;
    tbl[0] = '{coord: 2'b00, vec: 1'b0, big: 1'b0, n_iter: 16, steps: 16, ov_cycle: 18};
    tbl[1] = '{coord: 2'b01, vec: 1'b0, big: 1'b0, n_iter: 16, steps: 16, ov_cycle: 18};
    tbl[2] = '{coord: 2'b10, vec: 1'b1, big: 1'b0, n_iter: 16, steps: 17, ov_cycle: 19};
    tbl[3] = '{coord: 2'b00, vec: 1'b1, big: 1'b0, n_iter: 16, steps: 16, ov_cycle: 18};
    tbl[4] = '{coord: 2'b11, vec: 1'b0, big: 1'b0, n_iter: 16, steps: 17, ov_cycle: 19};
    tbl[5] = '{coord: 2'b10, vec: 1'b0, big: 1'b1, n_iter: 41, steps: 43, ov_cycle: 45};
    tbl[6] = '{coord: 2'b01, vec: 1'b1, big: 1'b1, n_iter: 41, steps: 41, ov_cycle: 43};

    for (int i = 0; i < 7; i++) begin
      use_b = tbl[i].big;
      do_reset();
      run_vec(tbl[i], 1'b1);
    end
    use_b = 1'b0;

    // DONE held: out_valid and busy stay high, start is ignored.
    do_reset();
    run_vec(tbl[0], 1'b0);
    start_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_i); #1;
      chk("hold_ov", 32'(m_ov), 1);
      chk("hold_busy", 32'(m_busy), 1);
      chk("hold_load", 32'(m_load), 0);
    end
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
    start_i = 1'b0;
    chk("ready_start_busy", 32'(m_busy), 0);
    chk("ready_start_load", 32'(m_load), 0);
    @(posedge clk_i); #1;
    chk("no_queue_busy", 32'(m_busy), 0);

    // Abort mid-ITER, then an immediate fresh run.
    coordinate_system_i = 2'b00; vectoring_i = 1'b0; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_shift(7, found);
    abort_i = 1'b1;
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    chk("abort_busy", 32'(m_busy), 0);
    chk("abort_ov", 32'(m_ov), 0);
    chk("abort_iter", 32'(m_iter), 0);
    run_vec(tbl[0], 1'b1);

    // Abort in IDLE is ignored and start still accepted; abort in LOAD flushes.
    abort_i = 1'b1; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk("idle_abort_load", 32'(m_load), 1);
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    chk("load_abort_busy", 32'(m_busy), 0);
    chk("load_abort_iter", 32'(m_iter), 0);

    // Abort in DONE drops the result.
    run_vec(tbl[0], 1'b0);
    abort_i = 1'b1;
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    chk("done_abort_ov", 32'(m_ov), 0);
    chk("done_abort_busy", 32'(m_busy), 0);

    // Asynchronous reset mid-run, then a normal run.
    coordinate_system_i = 2'b00; vectoring_i = 1'b0; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_shift(9, found);
    #2;
    rst_ni = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    run_vec(tbl[0], 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
